// File: rtl/check_parity_pkg.sv
`default_nettype none
// ============================================================================
// Module   : check_parity_pkg
// Brief    : Hamming(12,8) position maps and helpers shared with the encoder.
// Revision : 1.0 - initial release
// ============================================================================
package check_parity_pkg;

  localparam int c_SYN_W  = 4;
  localparam int c_CODE_W = 12;
  localparam int c_DATA_W = 8;

  localparam int c_PARITY_POS [0:3] = '{1, 2, 4, 8};
  localparam int c_DATA_POS   [0:7] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef logic [1:c_CODE_W]  codeword_t;
  typedef logic [1:c_DATA_W]  data_t;
  typedef logic [c_SYN_W-1:0] syndrome_t;

  function automatic data_t extractData(input codeword_t cw);
    data_t d;
    d = '0;
    for (int i = 0; i < c_DATA_W; i++) begin
      d[i+1] = cw[c_DATA_POS[i]];
    end
    return d;
  endfunction

  // Syndromes outside 1..12 name no position, so nothing is flipped for them.
  function automatic codeword_t flipPosition(input codeword_t cw, input syndrome_t s);
    codeword_t r;
    r = cw;
    for (int p = 1; p <= c_CODE_W; p++) begin
      if (s == syndrome_t'(p)) begin
        r[p] = ~r[p];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/check_parity_if.sv
`default_nettype none
// ============================================================================
// Module   : check_parity_if
// Brief    : Codeword-in / corrected-data-out valid-ready stream bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface check_parity_if;
  import check_parity_pkg::*;

  logic      in_valid;
  logic      in_ready;
  codeword_t dataIn;
  logic      out_valid;
  logic      out_ready;
  data_t     dataOut;
  logic      corrected;
  logic      uncorrectable;

  modport master (
    output in_valid, dataIn, out_ready,
    input  in_ready, out_valid, dataOut, corrected, uncorrectable
  );

  modport slave (
    input  in_valid, dataIn, out_ready,
    output in_ready, out_valid, dataOut, corrected, uncorrectable
  );

endinterface
`default_nettype wire

// File: rtl/check_parity_syndrome.sv
`default_nettype none
// ============================================================================
// Module   : hamming_syndrome
// Brief    : Combinational Hamming(12,8) syndrome of a 12-bit codeword.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_syndrome
  import check_parity_pkg::*;
(
  input  codeword_t dataIn,
  output syndrome_t s
);

  // Parity bit k covers every position whose index shares its single set bit.
  always_comb begin
    s = '0;
    for (int k = 0; k < c_SYN_W; k++) begin
      for (int p = 1; p <= c_CODE_W; p++) begin
        if ((p & c_PARITY_POS[k]) != 0) begin
          s[k] = s[k] ^ dataIn[p];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/check_parity.sv
`default_nettype none
// ============================================================================
// Module   : check_parity
// Brief    : Two-stage Hamming(12,8) SEC checker with saturating error counters.
// Revision : 1.0 - initial release
// ============================================================================
module check_parity
  import check_parity_pkg::*;
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             reset,
  check_parity_if.slave    bus,
  input  logic             clear_counts,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] err_count
);

  logic             r_s1Valid;
  codeword_t        r_s1Code;
  syndrome_t        r_s1Syn;
  logic             r_s2Valid;
  data_t            r_s2Data;
  logic             r_s2Corr;
  logic             r_s2Unc;
  logic [CNT_W-1:0] r_corrCount;
  logic [CNT_W-1:0] r_errCount;

  syndrome_t w_syn;
  logic      w_s1Adv;
  logic      w_s2Adv;
  logic      w_inXfer;
  logic      w_outXfer;
  data_t     w_fixData;
  logic      w_fixCorr;
  logic      w_fixUnc;

  assign w_s2Adv   = !r_s2Valid || bus.out_ready;
  assign w_s1Adv   = !r_s1Valid || w_s2Adv;
  assign w_inXfer  = bus.in_valid && w_s1Adv;
  assign w_outXfer = r_s2Valid && bus.out_ready;

  hamming_syndrome u_syndrome (
    .dataIn (bus.dataIn),
    .s      (w_syn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1Valid <= 1'b0;
      r_s1Code  <= '0;
      r_s1Syn   <= '0;
    end else if (w_s1Adv) begin
      r_s1Valid <= bus.in_valid;
      if (w_inXfer) begin
        r_s1Code <= bus.dataIn;
        r_s1Syn  <= w_syn;
      end
    end
  end

  always_comb begin
    w_fixCorr = (r_s1Syn != '0) && (r_s1Syn <= syndrome_t'(c_CODE_W));
    w_fixUnc  = (r_s1Syn > syndrome_t'(c_CODE_W));
    w_fixData = extractData(flipPosition(r_s1Code, r_s1Syn));
  end

  // Payload only loads with a real word so a stalled output never changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2Valid <= 1'b0;
      r_s2Data  <= '0;
      r_s2Corr  <= 1'b0;
      r_s2Unc   <= 1'b0;
    end else if (w_s2Adv) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_s2Data <= w_fixData;
        r_s2Corr <= w_fixCorr;
        r_s2Unc  <= w_fixUnc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_corrCount <= '0;
      r_errCount  <= '0;
    end else if (clear_counts) begin
      r_corrCount <= '0;
      r_errCount  <= '0;
    end else if (w_outXfer) begin
      if (r_s2Corr && (r_corrCount != '1)) begin
        r_corrCount <= r_corrCount + CNT_W'(1);
      end
      if (r_s2Unc && (r_errCount != '1)) begin
        r_errCount <= r_errCount + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready      = w_s1Adv;
  assign bus.out_valid     = r_s2Valid;
  assign bus.dataOut       = r_s2Data;
  assign bus.corrected     = r_s2Corr;
  assign bus.uncorrectable = r_s2Unc;
  assign corr_count        = r_corrCount;
  assign err_count         = r_errCount;

endmodule
`default_nettype wire

// File: tb/tb_check_parity.sv
`default_nettype none
// ============================================================================
// Module   : tb_check_parity
// Brief    : Directed vector bench for check_parity (CNT_W=8 and CNT_W=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_check_parity;

  logic       clk;
  logic       reset;
  logic       clear_counts;
  logic [7:0] corrA;
  logic [7:0] errA;
  logic [1:0] corrB;
  logic [1:0] errB;

  int nPass  = 0;
  int nTotal = 0;

  check_parity_if busA ();
  check_parity_if busB ();

  assign busB.in_valid  = busA.in_valid;
  assign busB.dataIn    = busA.dataIn;
  assign busB.out_ready = busA.out_ready;

  check_parity #(.CNT_W(8)) dutA (
    .clk          (clk),
    .reset        (reset),
    .bus          (busA),
    .clear_counts (clear_counts),
    .corr_count   (corrA),
    .err_count    (errA)
  );

  check_parity #(.CNT_W(2)) dutB (
    .clk          (clk),
    .reset        (reset),
    .bus          (busB),
    .clear_counts (clear_counts),
    .corr_count   (corrB),
    .err_count    (errB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] code;
    logic [7:0]  data;
    logic        corr;
    logic        unc;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [11:0] code);
    busA.in_valid = 1'b1;
    busA.dataIn   = code;
    step();
    busA.in_valid = 1'b0;
    step();
    step();
  endtask

  logic [11:0] words  [4];
  logic [7:0]  expOut [4];

  initial begin
    // {codeword, expected data, corrected, uncorrectable}
    vecs[0]  = '{12'hEEF, 8'hFF, 1'b0, 1'b0};  // clean, data FF
    vecs[1]  = '{12'h000, 8'h00, 1'b0, 1'b0};  // clean, data 00
    vecs[2]  = '{12'h080, 8'h00, 1'b1, 1'b0};  // pos 5 flipped
    vecs[3]  = '{12'h801, 8'h01, 1'b0, 1'b1};  // pos 1+12, s=13
    vecs[4]  = '{12'hCEF, 8'hFF, 1'b1, 1'b0};  // pos 3 flipped
    vecs[5]  = '{12'h6EF, 8'hFF, 1'b1, 1'b0};  // parity pos 1 flipped
    vecs[6]  = '{12'hEEE, 8'hFF, 1'b1, 1'b0};  // pos 12 flipped
    vecs[7]  = '{12'hE65, 8'hA5, 1'b1, 1'b0};  // data A5, pos 7 flipped
    vecs[8]  = '{12'hE15, 8'h85, 1'b0, 1'b1};  // pos 6+8, s=14
    vecs[9]  = '{12'hE75, 8'hB5, 1'b0, 1'b1};  // pos 7+8, s=15
    vecs[10] = '{12'hC6F, 8'h1F, 1'b1, 1'b0};  // pos 3+5 -> s=6 miscorrect
    words[0] = 12'hEEF; expOut[0] = 8'hFF;
    words[1] = 12'hE45; expOut[1] = 8'hA5;
    words[2] = 12'h000; expOut[2] = 8'h00;
    words[3] = 12'h6EF; expOut[3] = 8'hFF;

    reset          = 1'b1;
    clear_counts   = 1'b0;
    busA.in_valid  = 1'b0;
    busA.dataIn    = '0;
    busA.out_ready = 1'b1;
    step();
    step();
    check("reset out_valid", busA.out_valid, 0);
    check("reset dataOut", busA.dataOut, 0);
    check("reset corrected", busA.corrected, 0);
    check("reset uncorrectable", busA.uncorrectable, 0);
    check("reset corr_count", corrA, 0);
    check("reset err_count", errA, 0);
    reset = 1'b0;
    #1;
    check("release in_ready", busA.in_ready, 1);

    // Single-word transactions with latency check
    for (int i = 0; i < 11; i++) begin
      busA.in_valid = 1'b1;
      busA.dataIn   = vecs[i].code;
      #1;
      check("vec in_ready", busA.in_ready, 1);
      step();
      busA.in_valid = 1'b0;
      check("vec latency out_valid low", busA.out_valid, 0);
      step();
      check("vec out_valid", busA.out_valid, 1);
      check("vec dataOut", busA.dataOut, vecs[i].data);
      check("vec corrected", busA.corrected, vecs[i].corr);
      check("vec uncorrectable", busA.uncorrectable, vecs[i].unc);
      check("vec B dataOut", busB.dataOut, vecs[i].data);
      check("vec B flags", {busB.corrected, busB.uncorrectable}, {vecs[i].corr, vecs[i].unc});
      step();
      check("vec drained", busA.out_valid, 0);
    end
    check("table corr_count A", corrA, 6);
    check("table err_count A", errA, 3);
    check("table corr_count B sat", corrB, 3);
    check("table err_count B sat", errB, 3);

    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    check("clear corr_count", corrA, 0);
    check("clear err_count", errA, 0);

    // Streaming with a 3-cycle output stall
    begin
      int     nIn;
      int     nOut;
      logic   holdPrev;
      logic   sawStall;
      logic [7:0] prevData;
      nIn      = 0;
      nOut     = 0;
      holdPrev = 1'b0;
      sawStall = 1'b0;
      prevData = '0;
      for (int cyc = 0; cyc < 40 && nOut < 4; cyc++) begin
        busA.out_ready = !(cyc >= 3 && cyc <= 5);
        busA.in_valid  = (nIn < 4);
        busA.dataIn    = words[(nIn < 4) ? nIn : 0];
        #1;
        if (busA.in_valid && !busA.in_ready) sawStall = 1'b1;
        if (holdPrev) begin
          check("stall out_valid held", busA.out_valid, 1);
          check("stall dataOut held", busA.dataOut, prevData);
        end
        holdPrev = busA.out_valid && !busA.out_ready;
        prevData = busA.dataOut;
        if (busA.out_valid && busA.out_ready) begin
          check("stream order", busA.dataOut, expOut[(nOut < 4) ? nOut : 0]);
          nOut++;
        end
        if (busA.in_valid && busA.in_ready) nIn++;
        step();
      end
      busA.in_valid  = 1'b0;
      busA.out_ready = 1'b1;
      check("stream words delivered", nOut, 4);
      check("stream in_ready dropped", sawStall, 1);
    end
    step();
    check("stream drained", busA.out_valid, 0);

    // Saturation and clear-wins on a counting transfer
    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    for (int i = 0; i < 5; i++) sendWord(12'h6EF);
    check("sat corr_count B", corrB, 3);
    check("sat corr_count A", corrA, 5);
    busA.in_valid = 1'b1;
    busA.dataIn   = 12'h6EF;
    step();
    busA.in_valid = 1'b0;
    step();
    clear_counts = 1'b1;
    #1;
    check("6th word out_valid", busA.out_valid, 1);
    step();
    clear_counts = 1'b0;
    check("clear wins corr_count B", corrB, 0);
    check("clear wins corr_count A", corrA, 0);

    // Reset with two words in flight
    sendWord(12'h6EF);
    check("pre-reset corr_count", corrA, 1);
    busA.out_ready = 1'b0;
    busA.in_valid  = 1'b1;
    busA.dataIn    = 12'hEEF;
    step();
    busA.dataIn    = 12'hE45;
    step();
    busA.in_valid  = 1'b0;
    #1;
    check("in flight out_valid", busA.out_valid, 1);
    reset = 1'b1;
    #1;
    check("async reset out_valid", busA.out_valid, 0);
    check("async reset corr_count", corrA, 0);
    check("async reset dataOut", busA.dataOut, 0);
    step();
    step();
    reset          = 1'b0;
    busA.out_ready = 1'b1;
    #1;
    check("post-reset in_ready", busA.in_ready, 1);
    check("post-reset out_valid", busA.out_valid, 0);
    busA.in_valid = 1'b1;
    busA.dataIn   = 12'hE45;
    step();
    busA.in_valid = 1'b0;
    check("post-reset latency low", busA.out_valid, 0);
    step();
    check("post-reset out_valid", busA.out_valid, 1);
    check("post-reset dataOut", busA.dataOut, 8'hA5);
    step();
    check("post-reset no stale word", busA.out_valid, 0);
    check("post-reset corr_count", corrA, 0);
    check("post-reset err_count", errA, 0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
`default_nettype wire
